mul_seq_param: RTL and testbench

Parametrised iterative multiplier, the next generation of the team's fixed 32x32 product block. It computes the full 2*WIDTH-bit product of two WIDTH-bit operands over WIDTH/RADIX_BITS cycles. A per-operand signedness mode covers unsigned, signed and mixed (MULHSU-style) products. The block sits between the datapath issue stage and writeback, with valid/ready handshakes on both the operand side and the result side.

---
 rtl/mul_seq_param.sv | 139 +++++++++++++
 tb/tb_mul_seq_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_param.sv
// mul_seq_param -- iterative WIDTH x WIDTH multiplier with per-operand signedness.
//
// Retires RADIX_BITS multiplier bits per cycle into a 2*WIDTH-bit accumulator.
// The product is registered one cycle after the last digit has been retired,
// so out_valid rises WIDTH/RADIX_BITS + 1 edges after the accept edge.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   in_valid / in_ready        operand handshake (in_a, in_b, in_sign_a, in_sign_b)
//   abort                      cancels an operation that is in CALC
//   out_valid / out_ready      result handshake (out_low, out_high)
//   busy                       registered, high whenever the block is not IDLE
module mul_seq_param #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sign_a,
  input  logic             in_sign_b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_low,
  output logic [WIDTH-1:0] out_high,
  output logic             busy
);

  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            last;      // all digits retired; next CALC edge publishes acc
  logic [PW-1:0]   mcand;     // extended multiplicand, shifted left per digit
  logic [WIDTH-1:0] mplier;   // multiplier, shifted right per digit
  logic            sign_b_q;
  logic [PW-1:0]   acc;

  logic [RADIX_BITS-1:0] digit;
  logic                  top_neg;
  logic [PW-1:0]         pp;

  // Partial product of the current digit. Lower digits are unsigned; the top
  // digit of a signed multiplier carries the sign bit, whose weight is negative.
  // Working modulo 2^PW keeps the truncated result exact for every mode.
  always_comb begin
    digit   = mplier[RADIX_BITS-1:0];
    top_neg = (cnt == '0) && sign_b_q && digit[RADIX_BITS-1];
    pp      = '0;
    for (int j = 0; j < RADIX_BITS; j++) begin
      if (digit[j]) begin
        if ((j == RADIX_BITS - 1) && top_neg) pp = pp - (mcand << j);
        else                                  pp = pp + (mcand << j);
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values; the datapath registers are reset too, since the result
  // outputs must read zero straight out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      sign_b_q  <= 1'b0;
      acc       <= '0;
      out_low   <= '0;
      out_high  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand     <= {{WIDTH{in_sign_a & in_a[WIDTH-1]}}, in_a};
            mplier    <= in_b;
            sign_b_q  <= in_sign_b;
            acc       <= '0;
            cnt       <= CW'(N - 1);
            last      <= 1'b0;
            state     <= CALC;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        CALC: begin
          if (abort) begin
            // Abort beats completion; the previous result stays on the outputs.
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else if (last) begin
            out_low   <= acc[WIDTH-1:0];
            out_high  <= acc[PW-1:WIDTH];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc    <= acc + pp;
            mcand  <= mcand << RADIX_BITS;
            mplier <= mplier >> RADIX_BITS;
            if (cnt == '0) last <= 1'b1;
            else           cnt  <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_param.sv
// tb_mul_seq_param -- directed bench for mul_seq_param.
// Two instances share the clock and reset: a 32-bit radix-4 (RADIX_BITS=2)
// unit and an 8-bit radix-16 (RADIX_BITS=4) unit.
module tb_mul_seq_param;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 32-bit instance
  logic        in_valid, in_ready, in_sign_a, in_sign_b, abort;
  logic        out_valid, out_ready, busy;
  logic [31:0] in_a, in_b, out_low, out_high;

  // 8-bit instance
  logic        in_valid8, in_ready8, in_sign_a8, in_sign_b8, abort8;
  logic        out_valid8, out_ready8, busy8;
  logic [7:0]  in_a8, in_b8, out_low8, out_high8;

  mul_seq_param #(.WIDTH(32), .RADIX_BITS(2)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sign_a(in_sign_a), .in_sign_b(in_sign_b),
    .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_low(out_low), .out_high(out_high),
    .busy(busy)
  );

  mul_seq_param #(.WIDTH(8), .RADIX_BITS(4)) dut8 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_sign_a(in_sign_a8), .in_sign_b(in_sign_b8),
    .abort(abort8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_low(out_low8), .out_high(out_high8),
    .busy(busy8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  // ---------------- 32-bit helpers ----------------
  task automatic start32(input logic [31:0] a, input logic [31:0] b,
                         input logic sa, input logic sb);
    @(negedge clk);
    in_a = a; in_b = b; in_sign_a = sa; in_sign_b = sb;
    in_valid = 1'b1;
    @(posedge clk);          // accept edge
    #1 in_valid = 1'b0;
    in_a = 32'h5A5A_A5A5;    // later input changes must not matter
    in_b = 32'hDEAD_BEEF;
  endtask

  task automatic wait_valid32(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_valid && cyc < 60);
  endtask

  task automatic consume32();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic mul32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sa, input logic sb, input logic [63:0] exp);
    int cyc;
    start32(a, b, sa, sb);
    wait_valid32(cyc);
    check({tag, "_latency"}, 64'(cyc), 64'd17);
    check({tag, "_product"}, {out_high, out_low}, exp);
    consume32();
    check({tag, "_idle_after"}, 64'({in_ready, out_valid, busy}), 64'b100);
  endtask

  // ---------------- 8-bit helper ----------------
  task automatic mul8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic sa, input logic sb, input logic [15:0] exp);
    int cyc;
    @(negedge clk);
    in_a8 = a; in_b8 = b; in_sign_a8 = sa; in_sign_b8 = sb;
    in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_valid8 && cyc < 20);
    check({tag, "_latency"}, 64'(cyc), 64'd3);
    check({tag, "_product"}, 64'({out_high8, out_low8}), 64'(exp));
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int seen;
    logic [63:0] held;

    rstn = 1'b0;
    in_valid = 0; in_a = 0; in_b = 0; in_sign_a = 0; in_sign_b = 0; abort = 0; out_ready = 0;
    in_valid8 = 0; in_a8 = 0; in_b8 = 0; in_sign_a8 = 0; in_sign_b8 = 0; abort8 = 0; out_ready8 = 0;
    #23 rstn = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("reset_flags", 64'({in_ready, out_valid, busy}), 64'b100);
    check("reset_result", {out_high, out_low}, 64'h0);
    check("reset_flags8", 64'({in_ready8, out_valid8, busy8}), 64'b100);

    // Arithmetic across signedness modes
    mul32("uu_max",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001);
    mul32("ss_m1",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001);
    mul32("su_m1",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001);
    mul32("us_m1",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0001);
    mul32("ss_minsq",  32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000);
    mul32("ss_mixed",  32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 64'hC000_0000_8000_0000);

    // Backpressure: hold out_ready low for 5 cycles in DONE
    start32(32'd6, 32'd7, 1'b0, 1'b0);
    wait_valid32(cyc);
    check("bp_latency", 64'(cyc), 64'd17);
    held = {out_high, out_low};
    check("bp_product", held, 64'd42);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_flags", 64'({out_valid, in_ready, busy}), 64'b101);
      check("bp_hold_result", {out_high, out_low}, 64'd42);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_idle", 64'({in_ready, out_valid, busy}), 64'b100);
    // New accept on the very next edge
    @(negedge clk);
    in_a = 32'd9; in_b = 32'd9; in_sign_a = 0; in_sign_b = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_reaccept", 64'({in_ready, busy}), 64'b01);
    wait_valid32(cyc);
    check("bp_reaccept_product", {out_high, out_low}, 64'd81);
    consume32();

    // Abort on the 8th CALC cycle; previous result (81) must persist
    start32(32'h1234_5678, 32'h0000_0100, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle", 64'({in_ready, out_valid, busy}), 64'b100);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    check("abort_keeps_result", {out_high, out_low}, 64'd81);
    mul32("after_abort", 32'd3, 32'd5, 1'b0, 1'b0, 64'h0000_0000_0000_000F);

    // Reset in the middle of CALC
    start32(32'd100, 32'd200, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_flags", 64'({out_valid, busy}), 64'b00);
    check("rst_mid_result", {out_high, out_low}, 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rst_release_ready", 64'({in_ready, busy}), 64'b10);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rst_no_valid", 64'(seen), 64'd0);

    // 8-bit, RADIX_BITS=4 instance
    mul8("w8_uu_max",  8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01);
    mul8("w8_ss_mix",  8'h80, 8'h7F, 1'b1, 1'b1, 16'hC080);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
